adder_input_stage: RTL and testbench
====================================

# adder_input_stage

Receiving end of the multiplier-to-adder handshake in the filter datapath. Accepts single-cycle `srdyi` pulses carrying two operands from the multiplier output register, adds them in a registered two-stage pipeline, and emits the sum with a one-cycle `srdyo` pulse. Returns the most recent completed sum on `add_prev` to the multiplier output register for the frame-end accumulate step. Flags operand overruns.

## Interface
- `WIDTH`, 32, operand and sum width
- `CLR_CNT`, 5'd0, `count_global` value that clears `add_prev` at frame start
- `clk` in 1: single clock, rising edge
- `GlobalReset` in 1: reset, synchronous and active-low
- `srdyi` in 1: operand-valid pulse, one cycle wide
- `count_global` in 5: global frame sequencer count
- `add1_i` in WIDTH: operand A, valid when `srdyi`=1
- `add2_i` in WIDTH: operand B, valid when `srdyi`=1
- `sum_o` out WIDTH: registered sum, valid when `srdyo`=1 and held afterwards
- `carry_o` out 1: carry-out of the most recent sum
- `srdyo` out 1: sum-valid pulse, exactly one cycle wide
- `add_prev` out WIDTH: last completed sum, fed back to the multiplier output register
- `busy` out 1: high in ADD and DONE
- `overrun` out 1: sticky, set when an `srdyi` pulse is dropped

## Operation
- Reset (`GlobalReset`=0 at a rising edge): state←IDLE. `sum_o`, `add_prev`, operand registers ←0. `carry_o`, `srdyo`, `busy`, `overrun` ←0. Reset overrides every other action. An in-flight operation is discarded and produces no `srdyo`.
- FSM states: IDLE, ADD, DONE.
  - IDLE: if `srdyi`=1, capture `add1_i` and `add2_i` into `a_q` and `b_q`, then go to ADD. Otherwise stay in IDLE.
  - ADD: `{carry_o, sum_o}` ← `a_q + b_q`, computed at WIDTH+1 bits; `sum_o` wraps modulo 2^WIDTH. Go to DONE. If `srdyi`=1 here, drop the operands, set `overrun`, and keep the current operation running.
  - DONE: `srdyo`=1 for this cycle only, and `add_prev` ← `sum_o`. If `srdyi`=1, capture new operands and go to ADD (back-to-back acceptance). Otherwise go to IDLE.
- Throughput: one operand pair every 2 cycles. This matches the producer's minimum `srdyi` spacing.
- `count_global`==`CLR_CNT`: clear `add_prev` to 0. If the same cycle is also DONE, the DONE update of `add_prev` wins over the clear.
- `sum_o` and `carry_o` hold their value until the next ADD cycle.
- `overrun` clears only on reset.

## Timing
- `srdyi` sampled high at edge N, with the block in IDLE or DONE → ADD at cycle N+1 → `srdyo` high during cycle N+2 → `sum_o` valid during N+2. Latency is 2 cycles.
- `add_prev` reflects the new sum from cycle N+3 onward. The multiplier side samples it no earlier than 3 cycles after its `srdyo`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `srdyi` pulses at N and N+2: `srdyo` at N+2 and N+4, no overrun.
- `srdyi` high at N and N+1: the second pulse is dropped and `overrun`=1 from N+2.
- `srdyi` held high continuously: pulses are accepted every other cycle. Each pulse arriving in ADD sets `overrun`.

## Test plan
- Reset: hold `GlobalReset`=0 for 2 cycles with `srdyi`=1 → all outputs 0, no `srdyo`. Release → IDLE, `busy`=0.
- Single add: `add1_i`=32'h0000_0005, `add2_i`=32'h0000_0007, `srdyi` pulse at N → `srdyo`=1 only at N+2, `sum_o`=32'hC, `carry_o`=0, and `add_prev`=32'hC from N+3.
- Wrap and carry: `add1_i`=32'hFFFF_FFFF, `add2_i`=32'h0000_0002 → `sum_o`=32'h1, `carry_o`=1.
- Back-to-back and overrun: pulses at N (1+2), N+2 (3+4), N+3 (9+9) → `srdyo` at N+2 with sum 3 and at N+4 with sum 7. The pulse at N+3 is dropped and `overrun`=1 from N+4, sticky.
- Frame clear: `count_global`=CLR_CNT while idle after sum 7 → `add_prev`=0 next cycle. Clear coinciding with DONE for 3+4 → `add_prev`=7.
- Mid-operation reset: assert reset in the ADD cycle → no `srdyo`, outputs 0, and the next pulse behaves as in the single-add case.

Source files
------------

// File: rtl/adder_input_stage.sv
// Receiving end of the multiplier-to-adder handshake: captures an operand
// pair, adds it over a registered two-stage pipeline and reports the sum.
module adder_input_stage #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] CLR_CNT = 5'd0
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             srdyi,
    input  logic [4:0]       count_global,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             srdyo,
    output logic [WIDTH-1:0] add_prev,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            sum_o    <= '0;
            carry_o  <= 1'b0;
            srdyo    <= 1'b0;
            add_prev <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            srdyo <= 1'b0;
            // Frame-start clear; a DONE update below takes precedence.
            if (count_global == CLR_CNT) begin
                add_prev <= '0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (srdyi) begin
                        r_a     <= add1_i;
                        r_b     <= add2_i;
                        r_state <= S_ADD;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                S_ADD: begin
                    {carry_o, sum_o} <= w_sum;
                    srdyo   <= 1'b1;
                    r_state <= S_DONE;
                    busy    <= 1'b1;
                    if (srdyi) begin
                        overrun <= 1'b1;
                    end
                end
                S_DONE: begin
                    add_prev <= sum_o;
                    if (srdyi) begin
                        r_a     <= add1_i;
                        r_b     <= add2_i;
                        r_state <= S_ADD;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_input_stage.sv
// Directed bench for adder_input_stage with a transaction-level reference
// model compared every cycle plus literal spot checks.
module tb_adder_input_stage;

    localparam int         W   = 32;
    localparam logic [4:0] CLR = 5'd0;
    localparam logic [4:0] NCL = 5'd3;

    logic          clk = 1'b0;
    logic          GlobalReset;
    logic          srdyi;
    logic [4:0]    count_global;
    logic [W-1:0]  add1_i, add2_i;
    logic [W-1:0]  sum_o, add_prev;
    logic          carry_o, srdyo, busy, overrun;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    adder_input_stage #(.WIDTH(W), .CLR_CNT(CLR)) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .srdyi(srdyi),
        .count_global(count_global),
        .add1_i(add1_i),
        .add2_i(add2_i),
        .sum_o(sum_o),
        .carry_o(carry_o),
        .srdyo(srdyo),
        .add_prev(add_prev),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a pulse is taken unless one was taken on the
    // previous edge; its result appears one edge later and is recorded
    // as the previous sum on the edge after that.
    logic [W-1:0] m_a, m_b, m_sum, m_prev;
    logic         m_carry, m_srdyo, m_busy, m_ovr;
    bit           m_took;

    always @(posedge clk) begin
        bit take;
        if (!GlobalReset) begin
            m_took = 0; m_sum = '0; m_carry = 0; m_srdyo = 0;
            m_prev = '0; m_busy = 0; m_ovr = 0;
        end else begin
            if (m_srdyo) m_prev = m_sum;
            else if (count_global == CLR) m_prev = '0;
            m_srdyo = m_took;
            if (m_took) begin
                logic [W:0] s;
                s = {1'b0, m_a} + {1'b0, m_b};
                m_sum = s[W-1:0];
                m_carry = s[W];
            end
            take = srdyi && !m_took;
            if (srdyi && m_took) m_ovr = 1;
            if (take) begin
                m_a = add1_i;
                m_b = add2_i;
            end
            m_busy = take || m_took;
            m_took = take;
        end
    end

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_sum", sum_o, m_sum);
            check("m_carry", W'(carry_o), W'(m_carry));
            check("m_srdyo", W'(srdyo), W'(m_srdyo));
            check("m_prev", add_prev, m_prev);
            check("m_busy", W'(busy), W'(m_busy));
            check("m_ovr", W'(overrun), W'(m_ovr));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        srdyi = v;
        add1_i = a;
        add2_i = b;
    endtask

    initial begin
        GlobalReset = 1'b0;
        count_global = NCL;
        drive(1'b1, 32'd1, 32'd1);
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_srdyo", W'(srdyo), '0);
        check("rst_sum", sum_o, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_ovr", W'(overrun), '0);
        GlobalReset = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        check("idle_busy", W'(busy), '0);

        // single add 5+7
        drive(1'b1, 32'h5, 32'h7);
        tick();
        drive(1'b0, '0, '0);
        check("add_n1_srdyo", W'(srdyo), '0);
        check("add_n1_busy", W'(busy), 32'd1);
        tick();
        check("add_srdyo", W'(srdyo), 32'd1);
        check("add_sum", sum_o, 32'hC);
        check("add_carry", W'(carry_o), '0);
        tick();
        check("add_srdyo_off", W'(srdyo), '0);
        check("add_prev", add_prev, 32'hC);
        tick();

        // wrap and carry
        drive(1'b1, 32'hFFFF_FFFF, 32'h2);
        tick();
        drive(1'b0, '0, '0);
        tick();
        check("wrap_sum", sum_o, 32'h1);
        check("wrap_carry", W'(carry_o), 32'd1);
        tick();
        check("wrap_prev", add_prev, 32'h1);

        // back-to-back with overrun and frame clear
        drive(1'b1, 32'd1, 32'd2);
        tick();
        drive(1'b0, '0, '0);
        tick();
        check("b2b_sum3", sum_o, 32'd3);
        check("b2b_srdyo3", W'(srdyo), 32'd1);
        drive(1'b1, 32'd3, 32'd4);
        tick();
        drive(1'b1, 32'd9, 32'd9);
        tick();
        drive(1'b0, '0, '0);
        check("b2b_sum7", sum_o, 32'd7);
        check("b2b_srdyo7", W'(srdyo), 32'd1);
        check("b2b_ovr", W'(overrun), 32'd1);
        count_global = CLR;
        tick();
        check("clr_done_wins", add_prev, 32'd7);
        tick();
        check("clr_idle", add_prev, '0);
        check("ovr_sticky", W'(overrun), 32'd1);
        count_global = NCL;
        tick();

        // reset during ADD
        drive(1'b1, 32'h5, 32'h7);
        tick();
        drive(1'b0, '0, '0);
        GlobalReset = 1'b0;
        tick();
        check("mid_srdyo", W'(srdyo), '0);
        check("mid_ovr", W'(overrun), '0);
        check("mid_busy", W'(busy), '0);
        GlobalReset = 1'b1;
        tick();
        check("mid_srdyo2", W'(srdyo), '0);
        drive(1'b1, 32'h5, 32'h7);
        tick();
        drive(1'b0, '0, '0);
        tick();
        check("post_sum", sum_o, 32'hC);
        check("post_srdyo", W'(srdyo), 32'd1);
        tick();

        // srdyi held high
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(i * 3 + 1), 32'(32'hFFFF_FFF0 + i));
            tick();
        end
        drive(1'b0, '0, '0);
        repeat (4) tick();
        check("cont_ovr", W'(overrun), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
